mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares the single unified memory port between the instruction-fetch unit and the load/store path of the RISC-V core. One transaction is outstanding at a time. Data accesses win by default, and a starvation counter guarantees fetch progress. A per-transaction timeout converts a hung memory into an error response. The block sits between the fetch/LSU stages and the memory model, replacing the direct memory hookup.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch is pending (1..15)
- TIMEOUT, 64, cycles in BUSY before an error response (2..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_rdata/if_err valid
- if_rdata  out  DATA_W  fetched word
- if_err  out  1  fetch timed out
- ls_req  in  1  data request; held with ls_* until ls_ack
- ls_we  in  1  1 = store
- ls_size  in  3  access size/sign code, func3 encoding, passed through unmodified
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_ack  out  1  one-cycle pulse; ls_rdata/ls_err valid
- ls_rdata  out  DATA_W  load data
- ls_err  out  1  data access timed out
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  store enable
- mem_size  out  3  size code
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completion, single-cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register: FETCH or DATA.
- IDLE: no request → stay. Only one requester active → grant it. Both active → grant DATA unless starve_cnt == STARVE_LIMIT, in which case grant FETCH.
- On grant: register the owner's address, we, size and wdata into the mem_* registers. Fetch grants always use we=0 and size=3'b010. Set mem_req=1. Clear tmo_cnt. Go to BUSY.
- starve_cnt: increments on each DATA grant made while if_req=1, saturating at STARVE_LIMIT. Clears to 0 on a FETCH grant.
- BUSY, mem_ack=1: capture mem_rdata into the owner's rdata register, err=0, mem_req=0, go to RESP.
- BUSY, no ack, tmo_cnt == TIMEOUT-1: rdata=0, err=1, mem_req=0, go to RESP. Otherwise tmo_cnt increments.
- RESP: the owner's ack=1 for exactly this cycle. No grant is made. Next state is IDLE.
- A mem_ack in IDLE or RESP is stale (late ack after a timeout) and is ignored.
- rdata/err registers hold their value until the next response to the same requester.
- The non-owner's ack never pulses. if_ack and ls_ack are never high together.

## Timing
- All outputs are registered.
- Reset state: FSM=IDLE, owner=DATA, starve_cnt=0, tmo_cnt=0. mem_req, mem_we, if_ack, ls_ack, if_err and ls_err are 0. mem_size, mem_addr, mem_wdata, if_rdata and ls_rdata are 0.
- Request sampled in IDLE at cycle 0 → mem_req=1 at cycle 1.
- mem_ack at cycle k → requester ack at cycle k+1 → IDLE at k+2, next grant sampled at k+2.
- Minimum period is 3 cycles per transaction with a zero-wait memory (ack in the first BUSY cycle).
- The requester deasserts or changes req only after seeing ack. The arbiter cannot re-grant a request it has just serviced, because RESP makes no grant.
- mem_ack in the same cycle the timeout fires: the ack wins, and the response carries err=0 with data.
- Reset asserted mid-transaction: immediate return to reset values, and the transaction is dropped without an ack. A mem_ack after reset release is stale and ignored.
- Requests deasserted illegally while BUSY: the transaction completes and the ack is still issued.

## Structure
- The shared package riscv_mem_pkg holds:
  - the FSM state enum and the owner enum;
  - the SIZE_WORD = 3'b010 constant;
  - the load/store size code constants, also used by the LSU.
- No sub-module. The FSM, the two counters and the capture registers live in one module, and the timeout counter width is derived from TIMEOUT.

## Test plan
- Single fetch, if_addr=0x100, memory acks 2 cycles after mem_req: mem_req rises at cycle 1, mem_addr=0x100, mem_size=3'b010, mem_we=0. if_ack pulses at cycle 4 with if_rdata=mem_rdata and if_err=0.
- Simultaneous first requests, ls store 0xDEADBEEF to 0x2000 with ls_size=3'b010, and if_req to 0x0: the store is granted first with mem_we=1. The fetch is granted in the IDLE cycle after ls_ack.
- Continuous ls_req plus continuous if_req, STARVE_LIMIT=4, zero-wait memory: grant order is D,D,D,D,F,D,D,D,D,F. starve_cnt returns to 0 after each F.
- TIMEOUT=8, memory never acks a load: mem_req stays high for 8 cycles then drops. ls_ack pulses with ls_err=1 and ls_rdata=0. A later stray mem_ack changes no output.
- Reset pulse during BUSY on a fetch: all outputs return to 0 immediately and no if_ack occurs. A fresh if_req after release is serviced normally.
- mem_ack coincident with the final timeout cycle: response err=0, rdata=mem_rdata.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory port: arbiter FSM and owner
// encodings, plus the func3-style access size codes that the LSU also uses.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_DATA  = 1'b0,
      OWN_FETCH = 1'b1
   } owner_t;

   localparam logic [2:0] SIZE_BYTE   = 3'b000;
   localparam logic [2:0] SIZE_HALF   = 3'b001;
   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam logic [2:0] SIZE_BYTE_U = 3'b100;
   localparam logic [2:0] SIZE_HALF_U = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around the
// shared memory port. The arbiter takes the slave view; the surrounding
// core and memory model take the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;

   logic              ls_req;
   logic              ls_we;
   logic [2:0]        ls_size;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_ack;
   logic [DATA_W-1:0] ls_rdata;
   logic              ls_err;

   logic              mem_req;
   logic              mem_we;
   logic [2:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
      input  mem_ack, mem_rdata,
      output if_ack, if_rdata, if_err,
      output ls_ack, ls_rdata, ls_err,
      output mem_req, mem_we, mem_size, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
      output mem_ack, mem_rdata,
      input  if_ack, if_rdata, if_err,
      input  ls_ack, ls_rdata, ls_err,
      input  mem_req, mem_we, mem_size, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction at a time; data wins ties unless fetch has been passed
// over STARVE_LIMIT times, and a hung memory is turned into an error reply.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

   arb_state_t       state_q, state_d;
   owner_t           owner_q;
   logic [3:0]       starve_q;
   logic [TMO_W-1:0] tmo_q;

   logic grant_fetch, grant_data, rsp_ok, rsp_tmo, rsp_done;

   assign rsp_done = rsp_ok | rsp_tmo;

   // Next-state and grant/response decisions for the current cycle
   always_comb begin
      state_d     = state_q;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      rsp_ok      = 1'b0;
      rsp_tmo     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.if_req && (!bus.ls_req || starve_q == STARVE_MAX)) begin
               grant_fetch = 1'b1;
            end else if (bus.ls_req) begin
               grant_data = 1'b1;
            end
            if (grant_fetch || grant_data) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.mem_ack) begin
               rsp_ok  = 1'b1;
               state_d = ST_RESP;
            end else if (tmo_q == TMO_LAST) begin
               rsp_tmo = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the winner's request onto the memory side and drop it on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q       <= OWN_DATA;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_size  <= 3'b000;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
      end else if (grant_fetch) begin
         owner_q       <= OWN_FETCH;
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= 1'b0;
         bus.mem_size  <= SIZE_WORD;
         bus.mem_addr  <= bus.if_addr;
         bus.mem_wdata <= {DATA_W{1'b0}};
      end else if (grant_data) begin
         owner_q       <= OWN_DATA;
         bus.mem_req   <= 1'b1;
         bus.mem_we    <= bus.ls_we;
         bus.mem_size  <= bus.ls_size;
         bus.mem_addr  <= bus.ls_addr;
         bus.mem_wdata <= bus.ls_wdata;
      end else if (rsp_done) begin
         bus.mem_req   <= 1'b0;
      end
   end

   // Starvation counter bounds how long a waiting fetch can be overtaken,
   // and the timeout counter measures how long the memory has been silent
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 4'd0;
         tmo_q    <= '0;
      end else begin
         if (grant_fetch) begin
            starve_q <= 4'd0;
         end else if (grant_data && bus.if_req && starve_q < STARVE_MAX) begin
            starve_q <= starve_q + 4'd1;
         end
         if (grant_fetch || grant_data) begin
            tmo_q <= '0;
         end else if (state_q == ST_BUSY && !rsp_done) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end
      end
   end

   // Deliver the response to the owner only; its data/error persist until
   // that requester's next response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.if_ack   <= 1'b0;
         bus.if_rdata <= {DATA_W{1'b0}};
         bus.if_err   <= 1'b0;
         bus.ls_ack   <= 1'b0;
         bus.ls_rdata <= {DATA_W{1'b0}};
         bus.ls_err   <= 1'b0;
      end else begin
         bus.if_ack <= rsp_done && (owner_q == OWN_FETCH);
         bus.ls_ack <= rsp_done && (owner_q == OWN_DATA);
         if (rsp_done && owner_q == OWN_FETCH) begin
            bus.if_rdata <= rsp_ok ? bus.mem_rdata : {DATA_W{1'b0}};
            bus.if_err   <= rsp_tmo;
         end
         if (rsp_done && owner_q == OWN_DATA) begin
            bus.ls_rdata <= rsp_ok ? bus.mem_rdata : {DATA_W{1'b0}};
            bus.ls_err   <= rsp_tmo;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction-level
// reference model of the arbitration, timeout and response rules.
module tb_mem_port_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 8;

   logic clk = 1'b0;
   logic rst;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Requester-side model state
   bit          if_pend, ls_pend;
   logic [31:0] if_addr_m, ls_addr_m, ls_wdata_m;
   logic        ls_we_m;
   logic [2:0]  ls_size_m;
   int          data_streak;
   bit          grant_hist[$];

   // Expected DUT outputs
   logic        exp_mem_req, exp_mem_we, exp_if_ack, exp_ls_ack, exp_if_err, exp_ls_err;
   logic [2:0]  exp_mem_size;
   logic [31:0] exp_mem_addr, exp_mem_wdata, exp_if_rdata, exp_ls_rdata;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string ph);
      checkValue({ph, " mem_req"},   32'(bus.mem_req),   32'(exp_mem_req));
      checkValue({ph, " mem_we"},    32'(bus.mem_we),    32'(exp_mem_we));
      checkValue({ph, " mem_size"},  32'(bus.mem_size),  32'(exp_mem_size));
      checkValue({ph, " mem_addr"},  bus.mem_addr,       exp_mem_addr);
      checkValue({ph, " mem_wdata"}, bus.mem_wdata,      exp_mem_wdata);
      checkValue({ph, " if_ack"},    32'(bus.if_ack),    32'(exp_if_ack));
      checkValue({ph, " if_rdata"},  bus.if_rdata,       exp_if_rdata);
      checkValue({ph, " if_err"},    32'(bus.if_err),    32'(exp_if_err));
      checkValue({ph, " ls_ack"},    32'(bus.ls_ack),    32'(exp_ls_ack));
      checkValue({ph, " ls_rdata"},  bus.ls_rdata,       exp_ls_rdata);
      checkValue({ph, " ls_err"},    32'(bus.ls_err),    32'(exp_ls_err));
   endtask

   task automatic applyStimulus();
      bus.if_req   = if_pend;
      bus.if_addr  = if_addr_m;
      bus.ls_req   = ls_pend;
      bus.ls_we    = ls_we_m;
      bus.ls_size  = ls_size_m;
      bus.ls_addr  = ls_addr_m;
      bus.ls_wdata = ls_wdata_m;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      if_pend = 0; ls_pend = 0;
      if_addr_m = '0; ls_addr_m = '0; ls_wdata_m = '0; ls_we_m = 0; ls_size_m = '0;
      data_streak = 0;
      exp_mem_req = 0; exp_mem_we = 0; exp_mem_size = '0; exp_mem_addr = '0; exp_mem_wdata = '0;
      exp_if_ack = 0; exp_ls_ack = 0; exp_if_err = 0; exp_ls_err = 0;
      exp_if_rdata = '0; exp_ls_rdata = '0;
   endtask

   task automatic raise_fetch(input logic [31:0] addr);
      if_pend = 1; if_addr_m = addr;
   endtask

   task automatic raise_data(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
      ls_pend = 1; ls_we_m = we; ls_size_m = size; ls_addr_m = addr; ls_wdata_m = wdata;
   endtask

   // One full transaction from the IDLE sampling cycle back to IDLE.
   // lat = BUSY cycles before the memory acks (>= TIMEOUT means never).
   task automatic run_txn(input int lat, input logic [31:0] rdata, input bit stale_idle);
      bit fetch_wins, done_ok;
      fetch_wins = if_pend && (!ls_pend || data_streak == STARVE_LIMIT);
      if (fetch_wins) data_streak = 0;
      else if (if_pend && data_streak < STARVE_LIMIT) data_streak++;
      exp_mem_req   = 1;
      exp_mem_addr  = fetch_wins ? if_addr_m : ls_addr_m;
      exp_mem_we    = fetch_wins ? 1'b0 : ls_we_m;
      exp_mem_size  = fetch_wins ? 3'b010 : ls_size_m;
      exp_mem_wdata = fetch_wins ? 32'h0 : ls_wdata_m;
      exp_if_ack = 0; exp_ls_ack = 0;
      applyStimulus();
      bus.mem_ack   = stale_idle;
      bus.mem_rdata = $urandom;
      tick();
      grant_hist.push_back(!bus.mem_addr[31]);
      checkOutput("grant");
      for (int i = 0; i < TIMEOUT; i++) begin
         bus.mem_ack   = (i == lat);
         bus.mem_rdata = (i == lat) ? rdata : $urandom;
         tick();
         bus.mem_ack = 0;
         if (i == lat || i == TIMEOUT - 1) break;
         checkOutput("busy");
      end
      done_ok = (lat < TIMEOUT);
      exp_mem_req = 0;
      if (fetch_wins) begin
         exp_if_ack = 1; exp_if_rdata = done_ok ? rdata : 32'h0; exp_if_err = !done_ok; if_pend = 0;
      end else begin
         exp_ls_ack = 1; exp_ls_rdata = done_ok ? rdata : 32'h0; exp_ls_err = !done_ok; ls_pend = 0;
      end
      checkOutput("resp");
      exp_if_ack = 0; exp_ls_ack = 0;
      applyStimulus();
      bus.mem_ack   = !done_ok;
      bus.mem_rdata = $urandom;
      tick();
      bus.mem_ack = 0;
      checkOutput("idle");
   endtask

   logic [9:0] starve_pattern;

   // Directed scenarios, then randomized traffic, then the summary line
   initial begin
      clear_model();
      rst = 1;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      applyStimulus();
      #1;
      checkOutput("reset");
      tick(); tick();
      rst = 0;
      checkOutput("post-reset");

      $display("[TB] single fetch");
      raise_fetch(32'h100);
      run_txn(2, 32'h1234_5678, 0);

      $display("[TB] simultaneous store and fetch");
      raise_data(1, 3'b010, 32'h2000, 32'hDEAD_BEEF);
      raise_fetch(32'h0);
      run_txn(0, 32'h0BAD_F00D, 0);
      run_txn(1, 32'h1357_9BDF, 0);

      $display("[TB] starvation pattern");
      grant_hist.delete();
      for (int n = 0; n < 10; n++) begin
         if (!if_pend) raise_fetch($urandom & 32'h7FFF_FFFC);
         if (!ls_pend) raise_data(0, 3'b010, 32'h8000_0000 | $urandom, $urandom);
         run_txn(0, $urandom, 0);
      end
      starve_pattern = 10'b1000010000;
      for (int n = 0; n < 10; n++) begin
         checkValue($sformatf("grant_order[%0d]", n), 32'(grant_hist[n]), 32'(starve_pattern[n]));
      end
      if (if_pend) run_txn(0, $urandom, 0);
      if (ls_pend) run_txn(0, $urandom, 0);

      $display("[TB] load timeout");
      raise_data(0, 3'b100, 32'h8000_0040, $urandom);
      run_txn(TIMEOUT + 3, $urandom, 0);
      raise_fetch(32'h44);
      run_txn(1, 32'hCAFE_0001, 1);

      $display("[TB] ack coincident with timeout");
      raise_fetch(32'h48);
      run_txn(TIMEOUT - 1, 32'hA5A5_5A5A, 0);

      $display("[TB] reset during busy fetch");
      raise_fetch(32'h200);
      applyStimulus();
      tick();
      tick();
      #2;
      rst = 1;
      #1;
      clear_model();
      applyStimulus();
      checkOutput("rst-async");
      tick();
      checkOutput("rst-held");
      rst = 0;
      bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
      tick();
      bus.mem_ack = 0;
      checkOutput("stale-after-rst");
      tick();
      checkOutput("idle-after-rst");
      raise_fetch(32'h204);
      run_txn(0, 32'h7777_0000, 0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 40; n++) begin
         if (!if_pend && $urandom_range(0, 1)) raise_fetch($urandom & 32'h7FFF_FFFC);
         if (!ls_pend && $urandom_range(0, 1))
            raise_data(1'($urandom), 3'($urandom), 32'h8000_0000 | $urandom, $urandom);
         if (!if_pend && !ls_pend) raise_fetch($urandom & 32'h7FFF_FFFC);
         run_txn($urandom_range(0, TIMEOUT + 2), $urandom, 1'($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global bound so a stuck run still terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
